// File: rtl/stk_pkg.sv
// Shared types and default sizing for the stk pipe AD-stage invalidation controller.
package stk_pkg;

    localparam int ENGS_N_DEF  = 4;
    localparam int CTX_N_DEF   = 2;
    localparam int QUEUE_N_DEF = 4;

    localparam int ENGID_W = $clog2(ENGS_N_DEF);
    localparam int CTXID_W = (CTX_N_DEF > 1) ? $clog2(CTX_N_DEF) : 1;

    typedef logic [ENGID_W-1:0] engid_t;
    typedef logic [CTXID_W-1:0] ctxid_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ctx_state_t;

endpackage

// File: rtl/queue_rf.sv
// Register-file FIFO; full/empty flags are registered from the next-state count.
module queue_rf #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full_r,
    output logic         empty_r,
    output logic         empty_nxt
);

    localparam int AW = $clog2(N);

    logic [W-1:0]  mem [N];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   cnt_r;
    logic [AW:0]   cnt_nxt;
    logic          push_ok;
    logic          pop_ok;

    // A push against a full queue is dropped even if a pop happens alongside it.
    always_comb begin
        push_ok   = push & ~full_r;
        pop_ok    = pop & ~empty_r;
        cnt_nxt   = cnt_r + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        empty_nxt = (cnt_nxt == '0);
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            cnt_r   <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (push_ok) wptr_r <= wptr_r + 1'b1;
            if (pop_ok)  rptr_r <= rptr_r + 1'b1;
            cnt_r   <= cnt_nxt;
            full_r  <= (cnt_nxt == (AW+1)'(N));
            empty_r <= empty_nxt;
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_r] <= push_dat;
    end

    assign head = mem[rptr_r];

endmodule

// File: rtl/stk_inv_ctx.sv
// One invalidation context: holds an engine id and walks IDLE -> REQ -> WAIT,
// looping back to REQ on each non-last uncached writeback round.
module stk_inv_ctx
    import stk_pkg::*;
#(
    parameter int EID_W = ENGID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp,
    input  logic [EID_W-1:0] disp_engid,
    input  logic             ack,
    input  logic             wrbk_vld,
    input  logic [EID_W-1:0] wrbk_engid,
    input  logic             wrbk_islast,
    output logic [1:0]       state,
    output logic [1:0]       state_nxt,
    output logic [EID_W-1:0] engid_r,
    output logic             kill,
    output logic             clr
);

    ctx_state_t state_r;
    ctx_state_t nxt;
    logic       hit;

    // Writeback hit decode and next-state selection.
    always_comb begin
        hit  = wrbk_vld && (state_r == WAIT) && (engid_r == wrbk_engid);
        kill = hit & ~wrbk_islast;
        clr  = hit & wrbk_islast;
        nxt  = state_r;
        case (state_r)
            IDLE:    if (disp) nxt = REQ;
            REQ:     if (ack)  nxt = WAIT;
            WAIT:    if (hit)  nxt = wrbk_islast ? IDLE : REQ;
            default: nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= nxt;
    end

    // Engine id is captured on dispatch only; meaningless while IDLE.
    always_ff @(posedge clk) begin
        if (disp) engid_r <= disp_engid;
    end

    assign state     = state_r;
    assign state_nxt = nxt;

endmodule

// File: rtl/stk_pipe_ad_inv_mc.sv
// Multi-context engine invalidation controller: command queue, in-order dispatch
// to free contexts, and a locking round-robin arbiter for the single issue port.
module stk_pipe_ad_inv_mc
    import stk_pkg::*;
#(
    parameter int ENGS_N  = ENGS_N_DEF,
    parameter int CTX_N   = CTX_N_DEF,
    parameter int QUEUE_N = QUEUE_N_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [$clog2(ENGS_N)-1:0]     i_push_dat,
    output logic                          o_full_r,
    output logic                          o_busy_r,
    input  logic                          i_iss_ack,
    output logic                          o_iss_req,
    output logic [$clog2(ENGS_N)-1:0]     o_iss_engid,
    input  logic                          i_wrbk_uc_vld_r,
    input  logic [$clog2(ENGS_N)-1:0]     i_wrbk_uc_engid_r,
    input  logic                          i_wrbk_uc_islast_r,
    output logic [ENGS_N-1:0]             o_active_set_d,
    output logic [ENGS_N-1:0]             o_active_clr_d,
    output logic                          o_rsp_inv_kill
);

    localparam int EID_W = $clog2(ENGS_N);
    localparam int CID_W = (CTX_N > 1) ? $clog2(CTX_N) : 1;

    function automatic logic [ENGS_N-1:0] onehot(input logic [EID_W-1:0] e);
        logic [ENGS_N-1:0] r;
        r    = '0;
        r[e] = 1'b1;
        return r;
    endfunction

    logic [EID_W-1:0] q_head;
    logic             q_empty_r;
    logic             q_empty_nxt;

    logic [1:0]       st     [CTX_N];
    logic [1:0]       st_nxt [CTX_N];
    logic [EID_W-1:0] eng_r  [CTX_N];
    logic [CTX_N-1:0] disp_vec;
    logic [CTX_N-1:0] ack_vec;
    logic [CTX_N-1:0] kill_vec;
    logic [CTX_N-1:0] clr_vec;
    logic [CTX_N-1:0] req_vec;

    logic             disp_any;
    logic             any_idle;
    logic             held;
    logic [CID_W-1:0] disp_idx;
    logic [CID_W-1:0] rr_ptr_r;
    logic             lock_r;
    logic [CID_W-1:0] lock_idx_r;
    logic [CID_W-1:0] rr_idx;
    logic [CID_W-1:0] sel;
    logic             found;
    int               k;
    logic             busy_nxt;

    queue_rf #(.N(QUEUE_N), .W(EID_W)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (i_push),
        .push_dat  (i_push_dat),
        .pop       (disp_any),
        .head      (q_head),
        .full_r    (o_full_r),
        .empty_r   (q_empty_r),
        .empty_nxt (q_empty_nxt)
    );

    for (genvar g = 0; g < CTX_N; g++) begin : g_ctx
        stk_inv_ctx #(.EID_W(EID_W)) u_ctx (
            .clk         (clk),
            .rst         (rst),
            .disp        (disp_vec[g]),
            .disp_engid  (q_head),
            .ack         (ack_vec[g]),
            .wrbk_vld    (i_wrbk_uc_vld_r),
            .wrbk_engid  (i_wrbk_uc_engid_r),
            .wrbk_islast (i_wrbk_uc_islast_r),
            .state       (st[g]),
            .state_nxt   (st_nxt[g]),
            .engid_r     (eng_r[g]),
            .kill        (kill_vec[g]),
            .clr         (clr_vec[g])
        );
    end

    // Dispatch the queue head to the lowest IDLE context unless its engine is already in flight.
    always_comb begin
        any_idle = 1'b0;
        held     = 1'b0;
        disp_idx = '0;
        for (int i = CTX_N - 1; i >= 0; i--) begin
            if (st[i] == IDLE) begin
                any_idle = 1'b1;
                disp_idx = CID_W'(i);
            end
        end
        for (int i = 0; i < CTX_N; i++) begin
            if ((st[i] != IDLE) && (eng_r[i] == q_head)) held = 1'b1;
        end
        disp_any = ~q_empty_r & any_idle & ~held;
        for (int i = 0; i < CTX_N; i++) begin
            disp_vec[i] = disp_any && (disp_idx == CID_W'(i));
        end
        o_active_set_d = disp_any ? onehot(q_head) : '0;
    end

    // Issue selection: first REQ context at or after the pointer, frozen while locked.
    always_comb begin
        found  = 1'b0;
        rr_idx = rr_ptr_r;
        k      = 0;
        for (int i = 0; i < CTX_N; i++) begin
            req_vec[i] = (st[i] == REQ);
        end
        for (int i = 0; i < CTX_N; i++) begin
            k = int'(rr_ptr_r) + i;
            if (k >= CTX_N) k = k - CTX_N;
            if (!found && req_vec[k]) begin
                found  = 1'b1;
                rr_idx = CID_W'(k);
            end
        end
        sel         = lock_r ? lock_idx_r : rr_idx;
        o_iss_req   = |req_vec;
        o_iss_engid = eng_r[sel];
        for (int i = 0; i < CTX_N; i++) begin
            ack_vec[i] = i_iss_ack && o_iss_req && (sel == CID_W'(i));
        end
    end

    // Round-robin pointer and grant lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r   <= '0;
            lock_r     <= 1'b0;
            lock_idx_r <= '0;
        end else if (o_iss_req && i_iss_ack) begin
            lock_r   <= 1'b0;
            rr_ptr_r <= (sel == CID_W'(CTX_N - 1)) ? '0 : sel + 1'b1;
        end else if (o_iss_req) begin
            lock_r     <= 1'b1;
            lock_idx_r <= sel;
        end
    end

    // Writeback strobes; at most one context can hit per cycle.
    always_comb begin
        o_rsp_inv_kill = |kill_vec;
        o_active_clr_d = '0;
        busy_nxt       = ~q_empty_nxt;
        for (int i = 0; i < CTX_N; i++) begin
            if (clr_vec[i]) o_active_clr_d = o_active_clr_d | onehot(eng_r[i]);
            if (st_nxt[i] != IDLE) busy_nxt = 1'b1;
        end
    end

    // Busy flag registered from next-state occupancy.
    always_ff @(posedge clk) begin
        if (rst) o_busy_r <= 1'b0;
        else     o_busy_r <= busy_nxt;
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full_r))
        else $error("push dropped while queue full");

endmodule
